// File: rtl/crypto_arb_pkg.sv
// Shared types and constants for the crypto engine stream arbiter.
package crypto_arb_pkg;

  localparam int unsigned IDX_W = 1;

  // Input 0 wins the first contention after reset.
  localparam logic [IDX_W-1:0] LAST_GRANT_RST = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/crypto_rr_pick.sv
// Combinational 2-way round-robin chooser: a lone requester wins, otherwise
// the input that did not own the previous packet.
module crypto_rr_pick
  import crypto_arb_pkg::*;
(
  input  logic [1:0]       valid,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] sel,
  output logic             any_valid
);

  always_comb begin
    sel       = ~last_grant;
    any_valid = |valid;
    case (valid)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      default: sel = ~last_grant;
    endcase
  end

endmodule

// File: rtl/crypto_stream_arbiter.sv
// Packet-granular 2:1 round-robin arbiter in front of the crypto engine.
// Optional per-input packet counters are enabled with CRYPTO_ARB_PKT_CNT_EN.
module crypto_stream_arbiter
  import crypto_arb_pkg::*;
#(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
  input  logic                            s0_axis_tvalid,
  input  logic                            s0_axis_tlast,
  output logic                            s0_axis_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
  input  logic                            s1_axis_tvalid,
  input  logic                            s1_axis_tlast,
  output logic                            s1_axis_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,

  output logic                            key_sel
`ifdef CRYPTO_ARB_PKT_CNT_EN
  ,
  input  logic                            pkt_cnt_clr,
  output logic [31:0]                     pkt_cnt0,
  output logic [31:0]                     pkt_cnt1
`endif
);

  arb_state_t       state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] pick_sel;
  logic [IDX_W-1:0] sel;
  logic             any_valid;
  logic             open;
  logic             hs;

  crypto_rr_pick u_pick (
    .valid      ({s1_axis_tvalid, s0_axis_tvalid}),
    .last_grant (last_grant),
    .sel        (pick_sel),
    .any_valid  (any_valid)
  );

  // Zero-latency mux; grant is locked for the whole packet in PKT.
  always_comb begin
    sel           = (state == PKT) ? grant : pick_sel;
    m_axis_tdata  = sel ? s1_axis_tdata  : s0_axis_tdata;
    m_axis_tkeep  = sel ? s1_axis_tkeep  : s0_axis_tkeep;
    m_axis_tuser  = sel ? s1_axis_tuser  : s0_axis_tuser;
    m_axis_tlast  = sel ? s1_axis_tlast  : s0_axis_tlast;
    m_axis_tvalid = axis_resetn & (sel ? s1_axis_tvalid : s0_axis_tvalid);
    open          = axis_resetn & m_axis_tready & ((state == PKT) | any_valid);
    s0_axis_tready = open & (sel == 1'b0);
    s1_axis_tready = open & (sel == 1'b1);
    hs            = m_axis_tvalid & m_axis_tready;
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_GRANT_RST;
      key_sel    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            key_sel <= sel;
            if (m_axis_tlast) begin
              last_grant <= sel;
            end else begin
              grant <= sel;
              state <= PKT;
            end
          end
        end
        PKT: begin
          if (hs && m_axis_tlast) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CRYPTO_ARB_PKT_CNT_EN
  // Clear has priority over a coincident end-of-packet increment.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      pkt_cnt0 <= 32'd0;
      pkt_cnt1 <= 32'd0;
    end else if (pkt_cnt_clr) begin
      pkt_cnt0 <= 32'd0;
      pkt_cnt1 <= 32'd0;
    end else if (hs && m_axis_tlast) begin
      if (sel == 1'b0) pkt_cnt0 <= pkt_cnt0 + 32'd1;
      else             pkt_cnt1 <= pkt_cnt1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crypto_stream_arbiter.sv
// Directed self-checking bench for crypto_stream_arbiter (honours CRYPTO_ARB_PKT_CNT_EN).
module tb_crypto_stream_arbiter;

  logic         axis_aclk = 1'b0;
  logic         axis_resetn;
  logic [255:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [31:0]  s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic [127:0] s0_axis_tuser, s1_axis_tuser, m_axis_tuser;
  logic         s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic         s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic         key_sel;
`ifdef CRYPTO_ARB_PKT_CNT_EN
  logic         pkt_cnt_clr;
  logic [31:0]  pkt_cnt0, pkt_cnt1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 axis_aclk = ~axis_aclk;

  crypto_stream_arbiter dut (
    .axis_aclk      (axis_aclk),
    .axis_resetn    (axis_resetn),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tkeep  (s0_axis_tkeep),
    .s0_axis_tuser  (s0_axis_tuser),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tkeep  (s1_axis_tkeep),
    .s1_axis_tuser  (s1_axis_tuser),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tready (s1_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .key_sel        (key_sel)
`ifdef CRYPTO_ARB_PKT_CNT_EN
    ,
    .pkt_cnt_clr    (pkt_cnt_clr),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int src, input logic v, input logic [31:0] d, input logic l);
    if (src == 0) begin
      s0_axis_tvalid = v; s0_axis_tdata = {8{d}}; s0_axis_tkeep = d;
      s0_axis_tuser  = {4{~d}}; s0_axis_tlast = l;
    end else begin
      s1_axis_tvalid = v; s1_axis_tdata = {8{d}}; s1_axis_tkeep = d;
      s1_axis_tuser  = {4{~d}}; s1_axis_tlast = l;
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] ed,
                           input logic el, input logic er0, input logic er1);
    check($sformatf("%s.tvalid", tag), m_axis_tvalid, ev);
    if (ev) begin
      check($sformatf("%s.tdata", tag), m_axis_tdata, {8{ed}});
      check($sformatf("%s.tkeep", tag), m_axis_tkeep, ed);
      check($sformatf("%s.tuser", tag), m_axis_tuser, {4{~ed}});
      check($sformatf("%s.tlast", tag), m_axis_tlast, el);
    end
    check($sformatf("%s.s0_tready", tag), s0_axis_tready, er0);
    check($sformatf("%s.s1_tready", tag), s1_axis_tready, er1);
  endtask

  task automatic nxt();
    @(posedge axis_aclk);
    #1;
  endtask

  initial begin
    logic exp_sel;
    axis_resetn   = 1'b0;
    m_axis_tready = 1'b1;
`ifdef CRYPTO_ARB_PKT_CNT_EN
    pkt_cnt_clr = 1'b0;
`endif
    set_src(0, 1'b1, 32'h0000_0001, 1'b0);
    set_src(1, 1'b1, 32'h0000_0002, 1'b0);
    #3;
    check("rst.tvalid", m_axis_tvalid, 1'b0);
    check("rst.s0_tready", s0_axis_tready, 1'b0);
    check("rst.s1_tready", s1_axis_tready, 1'b0);
    check("rst.key_sel", key_sel, 1'b0);
    @(negedge axis_aclk);
    @(negedge axis_aclk);
    axis_resetn = 1'b1;
    set_src(0, 1'b0, 32'h0, 1'b0);
    set_src(1, 1'b0, 32'h0, 1'b0);
    nxt();

    // Contention after reset: s0 packet first, then s1.
    set_src(0, 1'b1, 32'h10, 1'b0); set_src(1, 1'b1, 32'h20, 1'b0);
    @(negedge axis_aclk); check_out("cont.s0b0", 1, 32'h10, 0, 1, 0); nxt();
    check("cont.key0", key_sel, 1'b0);
    set_src(0, 1'b1, 32'h11, 1'b1);
    @(negedge axis_aclk); check_out("cont.s0b1", 1, 32'h11, 1, 1, 0); nxt();
    set_src(0, 1'b0, 32'h0, 1'b0);
    @(negedge axis_aclk); check_out("cont.s1b0", 1, 32'h20, 0, 0, 1); nxt();
    check("cont.key1", key_sel, 1'b1);
    set_src(1, 1'b1, 32'h21, 1'b1);
    @(negedge axis_aclk); check_out("cont.s1b1", 1, 32'h21, 1, 0, 1); nxt();
    set_src(1, 1'b0, 32'h0, 1'b0);
    @(negedge axis_aclk); check_out("cont.idle", 0, 32'h0, 0, 0, 0); nxt();

    // Mid-packet hold: s0 stalls for 4 cycles while s1 waits.
    set_src(0, 1'b1, 32'h30, 1'b0); set_src(1, 1'b1, 32'h40, 1'b0);
    @(negedge axis_aclk); check_out("hold.b0", 1, 32'h30, 0, 1, 0); nxt();
    for (int k = 0; k < 4; k++) begin
      set_src(0, 1'b0, 32'h31, 1'b0);
      @(negedge axis_aclk); check_out("hold.gap", 0, 32'h0, 0, 1, 0); nxt();
    end
    set_src(0, 1'b1, 32'h31, 1'b1);
    @(negedge axis_aclk); check_out("hold.b1", 1, 32'h31, 1, 1, 0); nxt();
    set_src(0, 1'b0, 32'h0, 1'b0); set_src(1, 1'b1, 32'h40, 1'b1);
    @(negedge axis_aclk); check_out("hold.s1", 1, 32'h40, 1, 0, 1); nxt();
    check("hold.key1", key_sel, 1'b1);
    set_src(1, 1'b0, 32'h0, 1'b0);

    // Single requester, 3-beat packet from s0.
    for (int k = 0; k < 3; k++) begin
      set_src(0, 1'b1, 32'hC0 + 32'(k), k == 2);
      @(negedge axis_aclk); check_out("single", 1, 32'hC0 + 32'(k), k == 2, 1, 0); nxt();
      check("single.key", key_sel, 1'b0);
    end
    set_src(0, 1'b0, 32'h0, 1'b0);

    // Back-pressure mid-packet; s1 waiting must not intrude.
    set_src(0, 1'b1, 32'h50, 1'b0);
    @(negedge axis_aclk); check_out("bp.b0", 1, 32'h50, 0, 1, 0); nxt();
    set_src(0, 1'b1, 32'h51, 1'b0); set_src(1, 1'b1, 32'h41, 1'b1);
    m_axis_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge axis_aclk); check_out("bp.stall", 1, 32'h51, 0, 0, 0); nxt();
    end
    m_axis_tready = 1'b1;
    @(negedge axis_aclk); check_out("bp.b1", 1, 32'h51, 0, 1, 0); nxt();
    set_src(0, 1'b1, 32'h52, 1'b1);
    @(negedge axis_aclk); check_out("bp.b2", 1, 32'h52, 1, 1, 0); nxt();
    set_src(0, 1'b0, 32'h0, 1'b0); set_src(1, 1'b0, 32'h0, 1'b0);

    // Single-beat packets from both inputs; last owner was s0, so s1 leads.
    for (int i = 0; i < 10; i++) begin
      exp_sel = (i % 2 == 0);
      set_src(0, 1'b1, 32'h600 + 32'(i), 1'b1);
      set_src(1, 1'b1, 32'h700 + 32'(i), 1'b1);
      @(negedge axis_aclk);
      check_out("alt", 1, exp_sel ? 32'h700 + 32'(i) : 32'h600 + 32'(i), 1, !exp_sel, exp_sel);
      nxt();
      check("alt.key", key_sel, exp_sel);
    end

    // Async reset while s1 owns a 4-beat packet (beat 2 on the bus).
    set_src(0, 1'b1, 32'h80, 1'b0); set_src(1, 1'b1, 32'h90, 1'b0);
    @(negedge axis_aclk); check_out("ar.b0", 1, 32'h90, 0, 0, 1); nxt();
    set_src(1, 1'b1, 32'h91, 1'b0);
    @(negedge axis_aclk); check_out("ar.b1", 1, 32'h91, 0, 0, 1); nxt();
    set_src(1, 1'b1, 32'h92, 1'b0);
    @(negedge axis_aclk); check_out("ar.b2", 1, 32'h92, 0, 0, 1);
    #2 axis_resetn = 1'b0;
    #1;
    check("ar.tvalid", m_axis_tvalid, 1'b0);
    check("ar.s0_tready", s0_axis_tready, 1'b0);
    check("ar.s1_tready", s1_axis_tready, 1'b0);
    check("ar.key_sel", key_sel, 1'b0);
`ifdef CRYPTO_ARB_PKT_CNT_EN
    check("ar.cnt0", pkt_cnt0, 32'd0);
    check("ar.cnt1", pkt_cnt1, 32'd0);
`endif
    @(negedge axis_aclk);
    axis_resetn = 1'b1;
    nxt();
    set_src(0, 1'b1, 32'hA0, 1'b1); set_src(1, 1'b1, 32'hB0, 1'b1);
    @(negedge axis_aclk); check_out("post.s0", 1, 32'hA0, 1, 1, 0); nxt();
`ifdef CRYPTO_ARB_PKT_CNT_EN
    check("cnt.after_s0.cnt0", pkt_cnt0, 32'd1);
    check("cnt.after_s0.cnt1", pkt_cnt1, 32'd0);
`endif
    set_src(0, 1'b0, 32'h0, 1'b0);
    @(negedge axis_aclk); check_out("post.s1", 1, 32'hB0, 1, 0, 1); nxt();
    check("post.key", key_sel, 1'b1);
`ifdef CRYPTO_ARB_PKT_CNT_EN
    check("cnt.after_s1.cnt1", pkt_cnt1, 32'd1);
    set_src(1, 1'b0, 32'h0, 1'b0); set_src(0, 1'b1, 32'hA1, 1'b1);
    pkt_cnt_clr = 1'b1;
    @(negedge axis_aclk); check_out("clr.s0", 1, 32'hA1, 1, 1, 0); nxt();
    pkt_cnt_clr = 1'b0;
    check("cnt.clr.cnt0", pkt_cnt0, 32'd0);
    check("cnt.clr.cnt1", pkt_cnt1, 32'd0);
    set_src(0, 1'b1, 32'hA2, 1'b1);
    @(negedge axis_aclk); nxt();
    check("cnt.inc.cnt0", pkt_cnt0, 32'd1);
`endif
    set_src(0, 1'b0, 32'h0, 1'b0); set_src(1, 1'b0, 32'h0, 1'b0);
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
